misao_shift_seq: RTL and testbench
==================================

// Module: misao_shift_seq
// PURPOSE
//  Parametrised multi-cycle shift/rotate unit for the MISA-O datapath.
//  Generalises the single-position SHL/SHR nibble shift: adds configurable width,
//  shift amount, arithmetic and rotate (incl. through-carry) modes, and STEP bits/cycle.
//  Driven by the control FSM over a start/busy/done handshake; result feeds ACC, flags feed BC/BEQZ.
// PARAMETERS
//  WIDTH  16                 operand width in bits (>=4)
//  STEP   1                  max bit positions shifted per cycle (1..WIDTH)
//  AMT_W  $clog2(WIDTH)+1    width of amount port; encodes 0..WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      request; accepted only when state==IDLE
//  op         in   3      000 SHL, 001 SHR, 010 ASR, 011 ROL, 100 ROR, 101 RCL, 110 RCR, 111 PASS
//  data_in    in   WIDTH  operand, sampled on accept
//  amount     in   AMT_W  positions, sampled on accept; values >WIDTH clamp to WIDTH
//  carry_in   in   1      carry seed for RCL/RCR, sampled on accept
//  carry_en   in   1      1: carry_out updated by this op; 0: carry_out holds (sampled on accept)
//  busy       out  1      shift in progress
//  done       out  1      one-cycle pulse: data_out/carry_out/zero valid
//  data_out   out  WIDTH  result; holds until next done
//  carry_out  out  1      last bit shifted/rotated out (see rules)
//  zero       out  1      data_out==0, updated with done
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; busy=0, done=0, data_out=0, carry_out=0, zero=1.
//  States: IDLE -> (start) SHIFT if N>0, else FIN; SHIFT -> SHIFT while rem>0 after step,
//    else FIN; FIN -> IDLE (done=1 for exactly this cycle). N = ceil(amt/STEP).
//  Latency: accept at edge k; busy=1 for cycles k+1..k+N; done=1 in cycle k+N+1.
//    amount=0 or op=PASS: busy never asserts, done at k+1, data_out=data_in, carry_out unchanged.
//  Each SHIFT cycle applies s=min(STEP,rem) single-bit steps, rem-=s (combinational loop of s bits).
//  Single-bit step rules (c = internal carry register, seeded with carry_in):
//    SHL: out=msb, shift left, lsb<=0        SHR: out=lsb, shift right, msb<=0
//    ASR: out=lsb, shift right, msb kept     ROL/ROR: rotate, out=bit rotated around
//    RCL: {c,x}<=ROL over WIDTH+1 bits       RCR: {x,c}<=ROR over WIDTH+1 bits
//    After every step c<=out. carry_out<=c at FIN only if carry_en latched =1.
//  SHL/SHR by WIDTH -> 0; ASR by WIDTH -> all sign bits; ROL/ROR by WIDTH -> identity.
//  start while busy/FIN: ignored, no queueing; operands of running op unaffected.
//  start asserted in FIN cycle: ignored; accepted next cycle (IDLE).
//  data_out, carry_out, zero change only at FIN (or reset); stable otherwise.
//  Reset mid-operation: aborts immediately, outputs to reset values, no done pulse.
//  Reserved behaviour none: all 8 op codes defined.
// TESTING
//  T1 WIDTH=4,STEP=1: SHL data=9 amt=1 carry_en=1 -> data_out=2, carry_out=1, done at k+2.
//  T2 WIDTH=4 follow-on: SHR data=2 amt=1 carry_en=1 -> data_out=1, carry_out=0, zero=0.
//  T3 WIDTH=16,STEP=1: ASR 0x8001 amt=4 -> 0xF800, carry_out=0, busy 4 cycles, done k+5;
//     RCL 0x8000 amt=1 carry_in=1 -> 0x0001, carry_out=1.
//  T4 WIDTH=16,STEP=4: ROR 0x1234 amt=6 -> 0xD048, busy exactly 2 cycles;
//     SHL 0xFFFF amt=16 -> 0x0000, zero=1, carry_out=1.
//  T5 amt=0 and op=PASS with carry_out=1, carry_en=1 -> data_out=data_in, carry_out stays 1,
//     busy never high, done at k+1; carry_en=0 on SHL 0x8000 amt=1 -> carry_out unchanged.
//  T6 start pulsed while busy -> ignored, result of first op only; rst=0 mid-SHIFT ->
//     busy=0, data_out=0, zero=1 same cycle, no done; new op after release completes normally.

Source files
------------

// File: rtl/misao_shift_seq.sv
// rtl/misao_shift_seq.sv - multi-cycle shift/rotate unit for the MISA-O datapath
//
// Purpose:
//   Performs SHL/SHR/ASR/ROL/ROR/RCL/RCR/PASS on a WIDTH-bit operand.
//   The shift runs over several cycles, at most STEP bit positions per cycle.
//   The control FSM drives it through a start/busy/done handshake.
//   The result goes to ACC, and zero/carry feed the branch logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request, accepted only in IDLE
//   op         000 SHL, 001 SHR, 010 ASR, 011 ROL, 100 ROR, 101 RCL, 110 RCR, 111 PASS
//   data_in    operand, sampled on accept
//   amount     bit positions, sampled on accept; values above WIDTH clamp to WIDTH
//   carry_in   carry seed for RCL/RCR, sampled on accept
//   carry_en   1: carry_out is updated by this op; 0: carry_out holds
//   busy       high while shift cycles are in progress
//   done       one-cycle pulse; data_out/carry_out/zero are valid
//   data_out   result, held until the next done
//   carry_out  last bit shifted or rotated out
//   zero       data_out == 0, updated together with done

module misao_shift_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             carry_in,
  input  logic             carry_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_RCL  = 3'd5;
  localparam logic [2:0] OP_RCR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working copy of the running operation, frozen at accept.
  logic [WIDTH-1:0] x_q;
  logic             c_q;
  logic [AMT_W-1:0] rem_q;
  logic [2:0]       op_q;
  logic             cen_q;

  logic             accept;
  logic [AMT_W-1:0] amt_clamp;
  logic             noop;
  logic [AMT_W-1:0] step_n;
  logic [AMT_W-1:0] rem_nxt;
  logic [WIDTH-1:0] x_nxt;
  logic             c_nxt;
  logic             last_step;

  // One single-bit step. The return value is {new carry, new operand}.
  // The new carry is always the bit that was shifted or rotated out.
  function automatic logic [WIDTH:0] step1(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] x,
    input logic             c
  );
    logic [WIDTH:0] r;
    r = {c, x};
    case (f_op)
      OP_SHL:  r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {x[0], 1'b0, x[WIDTH-1:1]};
      OP_ASR:  r = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
      OP_ROL:  r = {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR:  r = {x[0], x[0], x[WIDTH-1:1]};
      // The carry rotates as an extra (WIDTH+1)th bit.
      OP_RCL:  r = {x[WIDTH-1], x[WIDTH-2:0], c};
      OP_RCR:  r = {x[0], c, x[WIDTH-1:1]};
      default: r = {c, x};
    endcase
    return r;
  endfunction

  // Accept-side decode and per-cycle shift network.
  always_comb begin
    accept    = (state == S_IDLE) && start;
    amt_clamp = (amount > AMT_MAX) ? AMT_MAX : amount;
    noop      = (op == OP_PASS) || (amt_clamp == '0);

    step_n    = (rem_q < STEP_A) ? rem_q : STEP_A;
    rem_nxt   = rem_q - step_n;
    last_step = (rem_nxt == '0);

    // Chain of STEP single-bit stages. Only the first step_n stages are active.
    // This lets the final cycle apply fewer than STEP positions.
    x_nxt = x_q;
    c_nxt = c_q;
    for (int i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < step_n) begin
        {c_nxt, x_nxt} = step1(op_q, x_nxt, c_nxt);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = noop ? S_FIN : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  // The results are loaded on the edge that enters FIN.
  // They are therefore valid during the done cycle and unchanged at any other time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      c_q       <= 1'b0;
      rem_q     <= '0;
      op_q      <= OP_PASS;
      cen_q     <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else if (accept) begin
      x_q   <= data_in;
      c_q   <= carry_in;
      rem_q <= amt_clamp;
      op_q  <= op;
      // A zero-length op or PASS never touches carry_out, even with carry_en set.
      cen_q <= carry_en & ~noop;
      if (noop) begin
        data_out <= data_in;
        zero     <= (data_in == '0);
      end
    end else if (state == S_SHIFT) begin
      x_q   <= x_nxt;
      c_q   <= c_nxt;
      rem_q <= rem_nxt;
      if (last_step) begin
        data_out <= x_nxt;
        zero     <= (x_nxt == '0);
        if (cen_q) begin
          carry_out <= c_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_misao_shift_seq.sv
// tb/tb_misao_shift_seq.sv - scoreboard bench for misao_shift_seq (three configurations)

module tb_misao_shift_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  op;
  logic [15:0] d_in;
  logic [4:0]  amt;
  logic        cin;
  logic        cen;
  logic        start0, start1, start2;

  logic        busy0, done0, cout0, zero0;
  logic [3:0]  dout0;
  logic        busy1, done1, cout1, zero1;
  logic [15:0] dout1;
  logic        busy2, done2, cout2, zero2;
  logic [15:0] dout2;

  misao_shift_seq #(.WIDTH(4), .STEP(1)) u_w4 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .data_in(d_in[3:0]),
    .amount(amt[2:0]), .carry_in(cin), .carry_en(cen), .busy(busy0),
    .done(done0), .data_out(dout0), .carry_out(cout0), .zero(zero0)
  );

  misao_shift_seq #(.WIDTH(16), .STEP(1)) u_w16s1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .data_in(d_in),
    .amount(amt), .carry_in(cin), .carry_en(cen), .busy(busy1),
    .done(done1), .data_out(dout1), .carry_out(cout1), .zero(zero1)
  );

  misao_shift_seq #(.WIDTH(16), .STEP(4)) u_w16s4 (
    .clk(clk), .rst(rst), .start(start2), .op(op), .data_in(d_in),
    .amount(amt), .carry_in(cin), .carry_en(cen), .busy(busy2),
    .done(done2), .data_out(dout2), .carry_out(cout2), .zero(zero2)
  );

  int          sel;
  logic        s_busy, s_done, s_cout, s_zero;
  logic [15:0] s_data;

  always_comb begin
    s_busy = busy0; s_done = done0; s_cout = cout0; s_zero = zero0;
    s_data = {12'b0, dout0};
    case (sel)
      1: begin
        s_busy = busy1; s_done = done1; s_cout = cout1; s_zero = zero1; s_data = dout1;
      end
      2: begin
        s_busy = busy2; s_done = done2; s_cout = cout2; s_zero = zero2; s_data = dout2;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    int          lat;
    int          nbusy;
  } exp_t;

  exp_t        sb[$];
  int          wid[3];
  int          stp[3];
  logic [15:0] last_data[3];
  logic        last_carry[3];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Whole-operation reference. The shifts use plain arithmetic, and the rotates use masks.
  // The returned carry is the last bit that left the operand.
  function automatic logic [32:0] ref_op(input int w, input logic [2:0] f_op,
                                         input logic [31:0] x, input int n, input logic c_in);
    logic [31:0] m, sx, r, vv, vr, m1;
    logic        c;
    int          w1;
    m  = (32'h1 << w) - 32'h1;
    w1 = w + 1;
    m1 = (32'h1 << w1) - 32'h1;
    r  = x;
    c  = c_in;
    if (n != 0 && f_op != 3'd7) begin
      case (f_op)
        3'd0: begin r = (x << n) & m; c = x[w - n]; end
        3'd1: begin r = x >> n; c = x[n - 1]; end
        3'd2: begin
          sx = x[w - 1] ? (x | ~m) : x;
          r  = 32'($signed(sx) >>> n) & m;
          c  = x[n - 1];
        end
        3'd3: begin r = ((x << n) | (x >> (w - n))) & m; c = r[0]; end
        3'd4: begin r = ((x >> n) | (x << (w - n))) & m; c = r[w - 1]; end
        3'd5: begin
          vv = (32'(c_in) << w) | x;
          vr = ((vv << n) | (vv >> (w1 - n))) & m1;
          r  = vr & m;
          c  = vr[w];
        end
        default: begin
          vv = (x << 1) | 32'(c_in);
          vr = ((vv >> n) | (vv << (w1 - n))) & m1;
          r  = vr >> 1;
          c  = vr[0];
        end
      endcase
    end
    return {c, r};
  endfunction

  task automatic set_start(input int k, input logic v);
    case (k)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic run_op(input string tag, input int k, input logic [2:0] f_op,
                        input logic [15:0] data, input logic [4:0] f_amt,
                        input logic f_cin, input logic f_cen, input bit poke);
    exp_t        e, g;
    logic [32:0] rr;
    logic [15:0] prev;
    logic [31:0] xm;
    int          n, cnt, nb, bad, late;
    bit          got, noop;
    n  = (k == 0) ? int'(f_amt[2:0]) : int'(f_amt);
    if (n > wid[k]) n = wid[k];
    xm = 32'(data) & ((32'h1 << wid[k]) - 32'h1);
    noop = (n == 0) || (f_op == 3'd7);
    rr = ref_op(wid[k], f_op, xm, n, f_cin);
    e.data  = rr[15:0];
    e.carry = (f_cen && !noop) ? rr[32] : last_carry[k];
    e.zero  = (rr[15:0] == 16'h0);
    e.nbusy = noop ? 0 : (n + stp[k] - 1) / stp[k];
    e.lat   = e.nbusy + 1;
    prev = last_data[k];
    sel  = k;
    @(negedge clk);
    op = f_op; d_in = data; amt = f_amt; cin = f_cin; cen = f_cen;
    set_start(k, 1'b1);
    sb.push_back(e);
    last_data[k]  = e.data;
    last_carry[k] = e.carry;
    @(posedge clk);
    @(negedge clk);
    set_start(k, 1'b0);
    cnt = 1; nb = 0; bad = 0; got = 0;
    while (!got && cnt < 100) begin
      if (s_done) got = 1;
      else begin
        if (s_busy) nb++;
        if (s_data !== prev) bad = 1;
        // A second request during the shift, carrying different operands.
        if (poke && cnt == 1) begin
          d_in = ~data; op = 3'd0; amt = 5'd1;
          set_start(k, 1'b1);
        end else set_start(k, 1'b0);
        cnt++;
        @(negedge clk);
      end
    end
    set_start(k, 1'b0);
    check({tag, " done_seen"}, 32'(got), 32'd1);
    g = sb.pop_front();
    check({tag, " data"}, 32'(s_data), 32'(g.data));
    check({tag, " carry"}, 32'(s_cout), 32'(g.carry));
    check({tag, " zero"}, 32'(s_zero), 32'(g.zero));
    check({tag, " latency"}, 32'(cnt), 32'(g.lat));
    check({tag, " busy_cycles"}, 32'(nb), 32'(g.nbusy));
    check({tag, " stable"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(s_done), 32'd0);
    if (poke) begin
      late = 0;
      for (int i = 0; i < 6; i++) begin
        if (s_done || s_busy) late = 1;
        @(negedge clk);
      end
      check({tag, " no_second_op"}, 32'(late), 32'd0);
      check({tag, " data_kept"}, 32'(s_data), 32'(g.data));
    end
  endtask

  initial begin
    int busy_seen, done_seen;
    wid[0] = 4;  stp[0] = 1;
    wid[1] = 16; stp[1] = 1;
    wid[2] = 16; stp[2] = 4;
    for (int i = 0; i < 3; i++) begin
      last_data[i] = 16'h0; last_carry[i] = 1'b0;
    end
    sel = 0; rst = 1'b0; op = 3'd0; d_in = 16'h0; amt = 5'd0; cin = 1'b0; cen = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'({busy0, busy1, busy2}), 32'd0);
    check("rst done", 32'({done0, done1, done2}), 32'd0);
    check("rst data", 32'({dout0, dout1, dout2}), 32'd0);
    check("rst carry", 32'({cout0, cout1, cout2}), 32'd0);
    check("rst zero", 32'({zero0, zero1, zero2}), 32'h7);
    rst = 1'b1;
    @(negedge clk);

    run_op("t1_shl", 0, 3'd0, 16'h9, 5'd1, 1'b0, 1'b1, 0);
    run_op("t2_shr", 0, 3'd1, 16'h2, 5'd1, 1'b0, 1'b1, 0);
    run_op("w4_asr_clamp", 0, 3'd2, 16'h9, 5'd7, 1'b0, 1'b1, 0);
    run_op("w4_rol_full", 0, 3'd3, 16'h9, 5'd4, 1'b0, 1'b1, 0);
    run_op("w4_rcr", 0, 3'd6, 16'h5, 5'd2, 1'b1, 1'b1, 0);
    run_op("t3_asr", 1, 3'd2, 16'h8001, 5'd4, 1'b0, 1'b1, 0);
    run_op("t3_rcl", 1, 3'd5, 16'h8000, 5'd1, 1'b1, 1'b1, 0);
    run_op("w16_shr_full", 1, 3'd1, 16'hA5A5, 5'd16, 1'b0, 1'b1, 0);
    run_op("w16_ror_clamp", 1, 3'd4, 16'h1234, 5'd31, 1'b0, 1'b1, 0);
    run_op("t4_ror", 2, 3'd4, 16'h1234, 5'd6, 1'b0, 1'b1, 0);
    run_op("t4_shl_full", 2, 3'd0, 16'hFFFF, 5'd16, 1'b0, 1'b1, 0);
    run_op("t5_pass", 2, 3'd7, 16'hABCD, 5'd5, 1'b0, 1'b1, 0);
    run_op("t5_amt0", 2, 3'd0, 16'h5555, 5'd0, 1'b0, 1'b1, 0);
    run_op("t5_shr_c0", 2, 3'd1, 16'h0002, 5'd1, 1'b0, 1'b1, 0);
    run_op("t5_cen0", 2, 3'd0, 16'h8000, 5'd1, 1'b0, 1'b0, 0);
    run_op("w16s4_rcl", 2, 3'd5, 16'h8421, 5'd9, 1'b1, 1'b1, 0);
    run_op("t6_poke", 1, 3'd3, 16'hC3A5, 5'd5, 1'b0, 1'b1, 1);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", $urandom_range(0, 2), 3'($urandom_range(0, 7)), 16'($urandom),
             5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 0);
    end

    // Reset in the middle of a long shift.
    sel = 1;
    @(negedge clk);
    op = 3'd0; d_in = 16'hFFFF; amt = 5'd12; cin = 1'b0; cen = 1'b1; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_rst busy", 32'(s_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst busy", 32'(s_busy), 32'd0);
    check("t6_rst data", 32'(s_data), 32'd0);
    check("t6_rst zero", 32'(s_zero), 32'd1);
    check("t6_rst carry", 32'(s_cout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      last_data[i] = 16'h0; last_carry[i] = 1'b0;
    end
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (s_done) done_seen = 1;
      if (s_busy) busy_seen = 1;
      @(negedge clk);
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    check("t6_no_busy", 32'(busy_seen), 32'd0);
    run_op("t6_after_rst", 1, 3'd1, 16'h8001, 5'd3, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
